// File: rtl/snake_input_tick_ctrl_if.sv
// Game-control bundle between the input/tick controller and the snake engine.
//   start   : game-start strobe (controller -> engine)
//   move    : step strobe, held for MOVE_HOLD cycles (controller -> engine)
//   up/down/left/right : one-hot steering, stable while move=1 (controller -> engine)
//   running : 1 while a game is in progress (controller -> engine)
//   dead    : engine death flag, level (engine -> controller)
//   score   : engine score, unsigned (engine -> controller)
interface snake_input_tick_ctrl_if;
  logic       start;
  logic       move;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       running;
  logic       dead;
  logic [5:0] score;

  modport master (
    output start, move, up, down, left, right, running,
    input  dead, score
  );

  modport slave (
    input  start, move, up, down, left, right, running,
    output dead, score
  );
endinterface

// File: rtl/snake_input_tick_ctrl.sv
// Upstream stage of the snake movement engine: debounces the five board buttons,
// runs the game FSM (idle/start/run/step/over), emits the start pulse, the periodic
// move strobe and a one-hot steering direction held stable across each step.
// The step period shrinks with score down to MIN_PERIOD.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   btn_up..btn_start : raw asynchronous active-high buttons
//   bus (master)      : start/move/direction/running out, dead/score in
module snake_input_tick_ctrl #(
  parameter int unsigned DB_CYCLES   = 250000,
  parameter int unsigned BASE_PERIOD = 25000000,
  parameter int unsigned MIN_PERIOD  = 5000000,
  parameter int unsigned SPEEDUP     = 500000,
  parameter int unsigned MOVE_HOLD   = 32,
  parameter int unsigned START_LEN   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_start,
  snake_input_tick_ctrl_if.master        bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_STEP, S_OVER} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [31:0] SPAN = 32'(BASE_PERIOD - MIN_PERIOD);

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   opposite = DIR_DOWN;
      DIR_DOWN: opposite = DIR_UP;
      DIR_LEFT: opposite = DIR_RIGHT;
      default:  opposite = DIR_LEFT;
    endcase
  endfunction

  // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 start.
  logic [4:0]  btn_raw;
  logic [4:0]  sync1, sync2, db, press;
  logic [31:0] db_cnt [5];

  assign btn_raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  // press[i] is a registered 1-cycle pulse on the debounced 0->1 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_CYCLES - 1) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Step period; the floor test avoids unsigned underflow for large scores.
  logic [31:0] prod, p_calc, period_q;
  always_comb begin
    prod   = 32'(bus.score) * 32'(SPEEDUP);
    p_calc = (prod >= SPAN) ? 32'(MIN_PERIOD) : 32'(BASE_PERIOD) - prod;
  end

  state_t      state, state_d;
  dir_t        dir_cur, dir_cur_d, dir_pend, dir_pend_d, req;
  logic        req_v;
  logic [31:0] tick, tick_d, hold, hold_d;
  logic        start_q, move_q, running_q;

  always_comb begin
    state_d    = state;
    tick_d     = tick;
    hold_d     = hold;
    dir_cur_d  = dir_cur;
    dir_pend_d = dir_pend;

    req_v = 1'b1;
    if      (press[0]) req = DIR_UP;
    else if (press[1]) req = DIR_DOWN;
    else if (press[2]) req = DIR_LEFT;
    else if (press[3]) req = DIR_RIGHT;
    else begin
      req   = dir_pend;
      req_v = 1'b0;
    end

    // Only the highest-priority press is considered; a reversal is dropped.
    if ((state inside {S_START, S_RUN, S_STEP}) && req_v && (req != opposite(dir_cur)))
      dir_pend_d = req;

    case (state)
      S_IDLE, S_OVER: begin
        if (press[4]) begin
          state_d    = S_START;
          tick_d     = '0;
          hold_d     = '0;
          dir_cur_d  = DIR_RIGHT;
          dir_pend_d = DIR_RIGHT;
        end
      end
      S_START: begin
        if (hold == START_LEN - 1) begin
          state_d = S_RUN;
          hold_d  = '0;
          tick_d  = '0;
        end else begin
          hold_d = hold + 32'd1;
        end
      end
      S_RUN: begin
        tick_d = tick + 32'd1;
        if (bus.dead) begin
          state_d = S_OVER;
        end else if (press[4]) begin
          state_d    = S_START;
          tick_d     = '0;
          hold_d     = '0;
          dir_cur_d  = DIR_RIGHT;
          dir_pend_d = DIR_RIGHT;
        end else if (tick == period_q - 32'd1) begin
          state_d   = S_STEP;
          tick_d    = '0;
          hold_d    = '0;
          dir_cur_d = dir_pend;
        end
      end
      S_STEP: begin
        if (hold == MOVE_HOLD - 1) begin
          state_d = S_RUN;
          hold_d  = '0;
          tick_d  = '0;
        end else begin
          hold_d = hold + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered decodes of the next state so they align with the state
  // register and carry no combinational path from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick      <= '0;
      hold      <= '0;
      period_q  <= 32'(BASE_PERIOD);
      dir_cur   <= DIR_RIGHT;
      dir_pend  <= DIR_RIGHT;
      start_q   <= 1'b0;
      move_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_d;
      tick      <= tick_d;
      hold      <= hold_d;
      dir_cur   <= dir_cur_d;
      dir_pend  <= dir_pend_d;
      if (tick == '0) period_q <= p_calc;
      start_q   <= (state_d == S_START);
      move_q    <= (state_d == S_STEP);
      running_q <= (state_d inside {S_START, S_RUN, S_STEP});
    end
  end

  assign bus.start   = start_q;
  assign bus.move    = move_q;
  assign bus.running = running_q;
  assign bus.up      = (dir_cur == DIR_UP);
  assign bus.down    = (dir_cur == DIR_DOWN);
  assign bus.left    = (dir_cur == DIR_LEFT);
  assign bus.right   = (dir_cur == DIR_RIGHT);

endmodule

// File: tb/tb_snake_input_tick_ctrl.sv
// Directed bench for snake_input_tick_ctrl with small timing parameters.
module tb_snake_input_tick_ctrl;

  logic clk;
  logic rst_n;
  logic btn_up, btn_down, btn_left, btn_right, btn_start;

  snake_input_tick_ctrl_if bus ();

  snake_input_tick_ctrl #(
    .DB_CYCLES  (4),
    .BASE_PERIOD(40),
    .MIN_PERIOD (20),
    .SPEEDUP    (5),
    .MOVE_HOLD  (16),
    .START_LEN  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_start(btn_start),
    .bus      (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts falling-edge samples until move equals level (bounded by limit).
  task automatic wait_move(input logic level, input int limit, output int n);
    n = 0;
    while (bus.move !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_start(input logic level, input int limit, output int n);
    n = 0;
    while (bus.start !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n, h, l, rises;
  int sc_tab  [5] = '{3, 10, 4, 63, 0};
  int gap_tab [5] = '{41, 36, 36, 36, 56};

  initial begin
    rst_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    bus.dead  = 1'b0;
    bus.score = 6'd0;
    repeat (3) @(negedge clk);

    check("rst_start",   bus.start,   0);
    check("rst_move",    bus.move,    0);
    check("rst_running", bus.running, 0);
    check("rst_right",   bus.right,   1);
    check("rst_up",      bus.up,      0);
    check("rst_down",    bus.down,    0);
    check("rst_left",    bus.left,    0);

    rst_n = 1'b1;
    @(negedge clk);

    // Game start and first step timing.
    fork
      begin
        btn_start = 1'b1;
        repeat (10) @(negedge clk);
        btn_start = 1'b0;
      end
    join_none
    wait_start(1'b1, 30, n);
    check("start_seen",    bus.start,   1);
    check("start_running", bus.running, 1);
    check("start_right",   bus.right,   1);
    wait_start(1'b0, 20, n);
    check("start_len", n, 4);
    wait_move(1'b1, 100, n);
    check("first_move_delay", n, 40);
    check("no_start_with_move", bus.start, 0);
    wait_move(1'b0, 40, n);
    check("move_len", n, 16);

    // 3-cycle up glitch must not steer.
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    wait_move(1'b1, 100, n);
    check("glitch_run_len", n, 37);
    check("glitch_right", bus.right, 1);
    check("glitch_up",    bus.up,    0);
    wait_move(1'b0, 40, n);

    // Reversal (left while heading right) is ignored.
    btn_left = 1'b1;
    repeat (10) @(negedge clk);
    btn_left = 1'b0;
    wait_move(1'b1, 100, n);
    check("rev_right", bus.right, 1);
    check("rev_left",  bus.left,  0);
    wait_move(1'b0, 40, n);

    // up+left together: up wins, visible only from the next step.
    btn_up = 1'b1;
    btn_left = 1'b1;
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    btn_left = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_step_right", bus.right, 1);
    check("pre_step_up",    bus.up,    0);
    wait_move(1'b1, 100, n);
    check("prio_run_len", n, 15);
    check("prio_up",    bus.up,    1);
    check("prio_left",  bus.left,  0);
    check("prio_right", bus.right, 0);
    wait_move(1'b0, 40, n);
    check("prio_move_len", n, 16);

    // Step spacing versus score, including the floor and a large score.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.score = 6'(sc_tab[i]);
      wait_move(1'b1, 200, n);
      wait_move(1'b0, 40, h);
      wait_move(1'b1, 200, l);
      check($sformatf("spacing_score%0d", sc_tab[i]), h + l, gap_tab[i]);
      wait_move(1'b0, 40, n);
    end

    // Death in RUN ends the game; no further steps, direction frozen.
    repeat (5) @(negedge clk);
    bus.dead = 1'b1;
    @(negedge clk);
    check("dead_running", bus.running, 0);
    check("dead_move",    bus.move,    0);
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.move === 1'b1) rises++;
    end
    check("dead_no_move", rises, 0);
    check("dead_dir_up",  bus.up, 1);
    bus.dead = 1'b0;

    fork
      begin
        btn_start = 1'b1;
        repeat (10) @(negedge clk);
        btn_start = 1'b0;
      end
    join_none
    wait_start(1'b1, 30, n);
    check("restart_start", bus.start, 1);
    check("restart_right", bus.right, 1);
    check("restart_up",    bus.up,    0);
    wait_start(1'b0, 20, n);
    check("restart_len", n, 4);

    // Turn up, then reset in the middle of the move pulse.
    btn_up = 1'b1;
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    wait_move(1'b1, 100, n);
    check("turn_run_len", n, 30);
    check("turn_up", bus.up, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_move",    bus.move,    0);
    check("arst_start",   bus.start,   0);
    check("arst_running", bus.running, 0);
    check("arst_right",   bus.right,   1);
    check("arst_up",      bus.up,      0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_right", bus.right, 1);
    check("post_rst_move",  bus.move,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
